// File: rtl/dm_subword_ctrl.sv
// Byte/halfword/word data memory with a valid/ready request port, a fixed-latency response pipe
// and a post-reset clear sweep. Define DM_ALIGN_EXC_EN to make misaligned accesses fault.
module dm_subword_ctrl #(
    parameter int          DEPTH_WORDS  = 3072,
    parameter int          READ_LATENCY = 1,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_exc,
    output logic [31:0] rsp_pc,
    output logic        busy
);

    localparam int              AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0]     OFF_LIMIT = 33'(DEPTH_WORDS) << 2;
    localparam logic [AW-1:0]   LAST_IDX  = AW'(DEPTH_WORDS - 1);

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [AW-1:0]   clear_ptr;
    logic            clear_done;

    logic [31:0]     mem [DEPTH_WORDS];

    logic            accept;
    logic [31:0]     off;
    logic            in_range;
    logic            misaligned;
    logic            fault;
    logic [AW-1:0]   word_idx;
    logic [1:0]      lane;
    logic [3:0]      byte_en;
    logic [31:0]     wdata_lane;
    logic            store_en;
    logic [31:0]     rd_word;
    logic [31:0]     rd_shifted;
    logic [31:0]     load_data;

    logic            pipe_valid [READ_LATENCY];
    logic [31:0]     pipe_rdata [READ_LATENCY];
    logic            pipe_exc   [READ_LATENCY];
    logic [31:0]     pipe_pc    [READ_LATENCY];

    assign clear_done = (clear_ptr == LAST_IDX);
    assign busy       = (state == CLEAR);
    assign req_ready  = (state == READY);
    assign accept     = req_valid & req_ready;

    always_comb begin
        state_next = state;
        case (state)
            CLEAR:   if (clear_done) state_next = READY;
            READY:   state_next = READY;
            default: state_next = CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= CLEAR;
            clear_ptr <= '0;
        end else begin
            state <= state_next;
            if (state == CLEAR) begin
                clear_ptr <= clear_done ? '0 : clear_ptr + AW'(1);
            end
        end
    end

    // Subtraction wraps, so addresses below BASE_ADDR land far out of range.
    always_comb begin
        off      = req_addr - BASE_ADDR;
        in_range = ({1'b0, off} < OFF_LIMIT);
        word_idx = off[AW+1:2];
`ifdef DM_ALIGN_EXC_EN
        misaligned = ((req_size == SIZE_HALF) && off[0]) ||
                     ((req_size == SIZE_WORD) && (off[1:0] != 2'b00));
`else
        misaligned = 1'b0;
`endif
        fault = !in_range || (req_size == 2'b11) || misaligned;
    end

    // Halfwords and words ignore the low offset bits; with the alignment check
    // enabled those cases have already become faults.
    always_comb begin
        lane       = 2'b00;
        byte_en    = 4'b0000;
        wdata_lane = req_wdata;
        case (req_size)
            SIZE_BYTE: begin
                lane       = off[1:0];
                byte_en    = 4'b0001 << off[1:0];
                wdata_lane = {4{req_wdata[7:0]}};
            end
            SIZE_HALF: begin
                lane       = {off[1], 1'b0};
                byte_en    = off[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{req_wdata[15:0]}};
            end
            SIZE_WORD: begin
                lane       = 2'b00;
                byte_en    = 4'b1111;
                wdata_lane = req_wdata;
            end
            default: begin
                lane       = 2'b00;
                byte_en    = 4'b0000;
                wdata_lane = req_wdata;
            end
        endcase
    end

    assign store_en = accept && req_we && !fault;

    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clear_ptr] <= '0;
        end else if (store_en) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[word_idx][8*b +: 8] <= wdata_lane[8*b +: 8];
                end
            end
        end
    end

    // Read is combinational, so a load right after a store sees the new word.
    always_comb begin
        rd_word    = mem[word_idx];
        rd_shifted = rd_word >> {lane, 3'b000};
        load_data  = '0;
        if (!req_we && !fault) begin
            case (req_size)
                SIZE_BYTE: load_data = req_unsigned ? {24'b0, rd_shifted[7:0]}
                                                    : {{24{rd_shifted[7]}}, rd_shifted[7:0]};
                SIZE_HALF: load_data = req_unsigned ? {16'b0, rd_shifted[15:0]}
                                                    : {{16{rd_shifted[15]}}, rd_shifted[15:0]};
                SIZE_WORD: load_data = rd_word;
                default:   load_data = '0;
            endcase
        end
    end

    // Stage 0 captures on the accept edge; the output register adds the final edge,
    // so rsp_valid rises READ_LATENCY edges after acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_valid[i] <= 1'b0;
                pipe_rdata[i] <= '0;
                pipe_exc[i]   <= 1'b0;
                pipe_pc[i]    <= '0;
            end
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_exc   <= 1'b0;
            rsp_pc    <= '0;
        end else begin
            pipe_valid[0] <= accept;
            if (accept) begin
                pipe_rdata[0] <= load_data;
                pipe_exc[0]   <= fault;
                pipe_pc[0]    <= req_pc;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_rdata[i] <= pipe_rdata[i-1];
                pipe_exc[i]   <= pipe_exc[i-1];
                pipe_pc[i]    <= pipe_pc[i-1];
            end
            rsp_valid <= pipe_valid[READ_LATENCY-1];
            if (pipe_valid[READ_LATENCY-1]) begin
                rsp_rdata <= pipe_rdata[READ_LATENCY-1];
                rsp_exc   <= pipe_exc[READ_LATENCY-1];
                rsp_pc    <= pipe_pc[READ_LATENCY-1];
            end
        end
    end

endmodule

// File: tb/tb_dm_subword_ctrl.sv
// Scoreboard bench for dm_subword_ctrl: a byte-addressed model predicts each response,
// which is queued on drive and compared (data, fault, pc, latency) when rsp_valid pulses.
module tb_dm_subword_ctrl;

    localparam int          DEPTH = 16;
    localparam int          LAT   = 3;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_exc;
    logic [31:0] rsp_pc;
    logic        busy;

    typedef struct {
        logic [31:0] rdata;
        logic        exc;
        logic [31:0] pc;
        int          edge_no;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  model_bytes [4*DEPTH];
    int          tests;
    int          failures;
    int          pulses;
    int          edge_count;
    logic [31:0] pc_next;
    logic [31:0] last_exp_rdata;
    logic [31:0] last_exp_pc;

    dm_subword_ctrl #(
        .DEPTH_WORDS (DEPTH),
        .READ_LATENCY(LAT),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_pc      (req_pc),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_exc     (rsp_exc),
        .rsp_pc      (rsp_pc),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial edge_count = 0;
    always @(posedge clk) edge_count <= edge_count + 1;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic modelAccess(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               output logic [31:0] rdata, output logic exc);
        logic [31:0] offs;
        logic [7:0]  b0, b1;
        int          a;
        offs  = addr - BASE;
        exc   = (offs >= 32'(4*DEPTH)) || (size == 2'b11);
`ifdef DM_ALIGN_EXC_EN
        if (size == 2'b01 && offs[0]) exc = 1'b1;
        if (size == 2'b10 && offs[1:0] != 2'b00) exc = 1'b1;
`endif
        rdata = '0;
        if (!exc) begin
            a = int'(offs);
            if (size == 2'b01) a = a & ~1;
            if (size == 2'b10) a = a & ~3;
            if (we) begin
                model_bytes[a] = wdata[7:0];
                if (size != 2'b00) model_bytes[a+1] = wdata[15:8];
                if (size == 2'b10) begin
                    model_bytes[a+2] = wdata[23:16];
                    model_bytes[a+3] = wdata[31:24];
                end
            end else begin
                b0 = model_bytes[a];
                b1 = model_bytes[a+1];
                case (size)
                    2'b00:   rdata = uns ? {24'b0, b0} : {{24{b0[7]}}, b0};
                    2'b01:   rdata = uns ? {16'b0, b1, b0} : {{16{b1[7]}}, b1, b0};
                    default: rdata = {model_bytes[a+3], model_bytes[a+2], b1, b0};
                endcase
            end
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        int   waited;
        waited = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (req_ready !== 1'b1) begin
            checkOutput("ready_wait", 32'(req_ready), 32'd1);
            return;
        end
        modelAccess(we, size, uns, addr, wdata, e.rdata, e.exc);
        e.pc      = pc_next;
        e.edge_no = edge_count + 1 + LAT;
        sb.push_back(e);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        req_pc       = pc_next;
        pc_next      = pc_next + 32'd4;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Releases reset and measures the clear sweep; the model memory becomes all zero.
    task automatic releaseAndClear(input string tag);
        int   ready_at;
        logic busy_ok;
        ready_at = 0;
        busy_ok  = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 1; i <= 3 * DEPTH; i++) begin
            @(posedge clk);
            #1;
            if (req_ready === 1'b1) begin
                ready_at = i;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
        checkOutput({tag, "_len"}, 32'(ready_at), 32'(DEPTH));
        checkOutput({tag, "_busy_during"}, 32'(busy_ok), 32'd1);
        checkOutput({tag, "_busy_after"}, 32'(busy), 32'd0);
        for (int i = 0; i < 4 * DEPTH; i++) model_bytes[i] = 8'h00;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        checkOutput("drain", 32'(sb.size()), 32'd0);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rsp_valid === 1'b1) begin
            pulses++;
            checkOutput("rsp_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput("rsp_rdata", rsp_rdata, e.rdata);
                checkOutput("rsp_exc", 32'(rsp_exc), 32'(e.exc));
                checkOutput("rsp_pc", rsp_pc, e.pc);
                checkOutput("rsp_latency", 32'(edge_count), 32'(e.edge_no));
                last_exp_rdata = e.rdata;
                last_exp_pc    = e.pc;
            end
        end
    end

    initial begin
        int p0;
        tests        = 0;
        failures     = 0;
        pulses       = 0;
        pc_next      = 32'h0000_1000;
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        req_pc       = '0;
        repeat (3) @(negedge clk);

        checkOutput("reset_busy", 32'(busy), 32'd1);
        checkOutput("reset_ready", 32'(req_ready), 32'd0);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_rsp_rdata", rsp_rdata, 32'd0);
        checkOutput("reset_rsp_exc", 32'(rsp_exc), 32'd0);
        checkOutput("reset_rsp_pc", rsp_pc, 32'd0);

        releaseAndClear("clear");

        applyStimulus(1'b0, 2'b10, 1'b0, 32'h3C, 32'h0);
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'h8899AABB);
        applyStimulus(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h12, 32'h0);
        applyStimulus(1'b0, 2'b01, 1'b0, 32'h10, 32'h0);
        applyStimulus(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000CD);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        applyStimulus(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'(4*DEPTH), 32'h0);
        applyStimulus(1'b1, 2'b10, 1'b0, 32'(4*DEPTH), 32'hDEADBEEF);
        applyStimulus(1'b1, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'hCAFEF00D);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h00, 32'h0);
        applyStimulus(1'b1, 2'b01, 1'b0, 32'h21, 32'h00001234);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        applyStimulus(1'b1, 2'b11, 1'b0, 32'h04, 32'h55555555);
        applyStimulus(1'b0, 2'b11, 1'b0, 32'h04, 32'h0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h04, 32'h0);
        applyStimulus(1'b1, 2'b01, 1'b0, 32'h02, 32'h0000BEEF);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h00, 32'h0);
        applyStimulus(1'b0, 2'b01, 1'b0, 32'h02, 32'h0);
        applyStimulus(1'b0, 2'b01, 1'b1, 32'h02, 32'h0);

        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), 32'($urandom_range(0, 4*DEPTH + 12)),
                          $urandom);
        end
        drain();

        repeat (3) @(negedge clk);
        checkOutput("hold_rdata", rsp_rdata, last_exp_rdata);
        checkOutput("hold_pc", rsp_pc, last_exp_pc);

        applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        sb.delete();
        p0 = pulses;
        repeat (6) @(negedge clk);
        checkOutput("midreset_busy", 32'(busy), 32'd1);
        checkOutput("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
        releaseAndClear("reclear");
        repeat (LAT + 2) @(negedge clk);
        checkOutput("flush_pulses", 32'(pulses - p0), 32'd0);

        applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h00, 32'h0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/dm_subword_ctrl.md
Name: dm_subword_ctrl

Overview:
- Parametrised data memory for the single-cycle/pipelined CPU datapath.
- Supports byte, halfword and word loads and stores, with sign or zero extension.
- Uses a valid/ready request port and a fixed-latency pipelined response.
- After reset, a clear state machine zeroes memory one word per cycle; requests are refused until it finishes.

Parameters:
- DEPTH_WORDS, 3072: number of 32-bit words; legal range is 2 to 65536.
- READ_LATENCY, 1: cycles from request acceptance to rsp_valid; legal range is 1 to 4.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; word aligned.

Ports:
- clk  in  1: system clock, rising edge.
- reset  in  1: asynchronous, active-high reset.
- req_valid  in  1: request present.
- req_ready  out  1: block can accept a request this cycle.
- req_we  in  1: 1 = store, 0 = load.
- req_size  in  2: 00 = byte, 01 = halfword, 10 = word; 11 is illegal.
- req_unsigned  in  1: load zero-extends when 1, sign-extends when 0.
- req_addr  in  32: byte address.
- req_wdata  in  32: store data, right-aligned (byte in [7:0], halfword in [15:0]).
- req_pc  in  32: PC of the issuing instruction; carried to rsp_pc.
- rsp_valid  out  1: response valid; a one-cycle pulse per accepted request.
- rsp_rdata  out  32: extended load data; 0 for stores and faults.
- rsp_exc  out  1: access fault for this response.
- rsp_pc  out  32: req_pc of the request being answered.
- busy  out  1: high while the clear state machine runs.

Behaviour:
- Reset (asynchronous, high): state=CLEAR, clear_ptr=0.
  - All pipeline valid bits are 0.
  - Outputs: rsp_valid=0, rsp_rdata=0, rsp_exc=0, rsp_pc=0, req_ready=0, busy=1.
  - Memory contents are not touched asynchronously.
- CLEAR state:
  - Each clk edge writes mem[clear_ptr]<=0 and increments clear_ptr.
  - On the edge that writes index DEPTH_WORDS-1, go to READY.
  - Exactly DEPTH_WORDS cycles from reset release to req_ready=1.
  - busy = (state==CLEAR); req_ready = (state==READY), combinational from state.
- Reset asserted mid-clear or mid-operation:
  - Returns to CLEAR with clear_ptr=0.
  - In-flight responses are dropped and never pulse.
- Acceptance: req_valid & req_ready at a rising edge. One request per cycle max; no back-pressure on the response side.
- Address decode:
  - off = req_addr - BASE_ADDR; word index = off[31:2].
  - Out of range when off >= 4*DEPTH_WORDS, including wrap-around below BASE_ADDR.
  - Out-of-range access: store is suppressed, rdata=0, rsp_exc=1.
- Illegal req_size=11: treated as a fault; no write, rsp_exc=1.
- Store lane selection on the accept edge:
  - byte: lane off[1:0] gets wdata[7:0].
  - half: lanes {off[1],0} and {off[1],1} get wdata[15:0], low byte at the lower address (little-endian).
  - word: all four lanes.
  - Lanes not selected keep their old value.
- Load:
  - The word is read on the accept edge and the lane extracted per off[1:0].
  - Result is extended per req_unsigned to 32 bits.
- Response timing:
  - Response arrives exactly READ_LATENCY rising edges after the accept edge, through a shift pipeline of {valid, rdata, exc, pc}.
  - Stores also produce rsp_valid with rdata=0, so responses stay in request order.
- Ordering and hazards:
  - A load accepted the cycle after a store to the same word returns the post-store value.
  - Back-to-back accepts give back-to-back rsp_valid pulses.
- rsp_rdata, rsp_exc and rsp_pc hold their last value while rsp_valid=0.

Optional Feature:
- Macro DM_ALIGN_EXC_EN.
- Defined:
  - Misaligned access (half with off[0]=1, word with off[1:0]!=0) sets rsp_exc=1.
  - The store is suppressed and rdata=0.
- Undefined:
  - Misalignment is never a fault; the low address bits are forced aligned.
  - Half uses {off[1],0}; word uses 00.

Test Plan:
- Release reset with DEPTH_WORDS=16 -> busy=1 and req_ready=0 for exactly 16 cycles, then req_ready=1; a load of addr 0x3C returns 0x00000000.
- Store word 0x0000_0010 <= 0x8899AABB, then load byte unsigned at 0x13 -> rdata 0x00000088; load byte signed at 0x12 -> 0xFFFFFF99; load half signed at 0x10 -> 0xFFFFAABB.
- Store byte 0x11 <= 0x000000CD over word 0x8899AABB, then load word at 0x10 -> 0x8899CDBB; with READ_LATENCY=3, rsp_valid rises 3 edges after each accept, and rsp_pc matches each request.
- Load at addr 4*DEPTH_WORDS -> rsp_exc=1, rdata=0; store at the same address then load word 0 -> word 0 unchanged.
- With DM_ALIGN_EXC_EN, store half at 0x21 <= 0x1234 -> rsp_exc=1, no write. Without it, the same store writes lanes 0 and 1 of word 0x20, and a load word at 0x20 returns 0x00001234.
- Assert reset during a 2-deep in-flight load stream -> no rsp_valid pulse follows; the clear restarts from index 0.
